// File: rtl/digit_serial_adder_if.sv
// Valid/ready bundle for the digit-serial adder: operand request in, sum/flags response out.
interface digit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle ripple-carry adder: one DIGIT-bit slice plus a registered carry,
// walking the operands LS digit first; one operation in flight at a time.
//
// state  | meaning
// S_IDLE | ready for operands
// S_BUSY | adding digit cnt_q, carry held in carry_q
// S_DONE | result presented, waiting for out_ready
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                clk,
  input  logic                reset,
  digit_serial_adder_if.slave io
);
  localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("digit_serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [DIGIT-1:0] dig_a, dig_b, dig_s;
  logic             slice_c, slice_c_msb;

  // Ripple slice; slice_c_msb is the carry into the slice's top bit,
  // which on the last digit is the carry into bit WIDTH-1.
  always_comb begin
    dig_a       = a_q[int'(cnt_q)*DIGIT +: DIGIT];
    dig_b       = b_q[int'(cnt_q)*DIGIT +: DIGIT];
    dig_s       = '0;
    slice_c     = carry_q;
    slice_c_msb = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      slice_c_msb = slice_c;
      dig_s[i]    = dig_a[i] ^ dig_b[i] ^ slice_c;
      slice_c     = (dig_a[i] & dig_b[i]) | (slice_c & (dig_a[i] ^ dig_b[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          a_d     = io.a;
          b_d     = io.b;
          carry_d = io.c_in;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        sum_d[int'(cnt_q)*DIGIT +: DIGIT] = dig_s;
        carry_d = slice_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          c_out_d = slice_c;
          ovf_d   = slice_c_msb ^ slice_c;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.sum       = sum_q;
  assign io.c_out     = c_out_q;
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed handshake/reset cases on (8,2) and
// random operands on (8,2), (8,1), (8,8), (16,4) against an integer reference.
module tb_digit_serial_adder;
  localparam int NC = 4;
  localparam int CW [NC] = '{8, 8, 8, 16};
  localparam int CD [NC] = '{2, 1, 8, 4};

  logic clk;
  logic reset;

  logic [NC-1:0]       inv_v, cin_v, ordy_v;
  logic [NC-1:0][15:0] a_v, b_v;
  logic [NC-1:0]       ir_v, ov_v, co_v, of_v;
  logic [NC-1:0][15:0] sum_v;

  int n_vec = 0;
  int n_err = 0;

  genvar g;
  generate
    for (g = 0; g < NC; g++) begin : g_cfg
      digit_serial_adder_if #(.WIDTH(CW[g])) bus ();
      digit_serial_adder #(.WIDTH(CW[g]), .DIGIT(CD[g])) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
      );
      assign bus.in_valid  = inv_v[g];
      assign bus.a         = a_v[g][CW[g]-1:0];
      assign bus.b         = b_v[g][CW[g]-1:0];
      assign bus.c_in      = cin_v[g];
      assign bus.out_ready = ordy_v[g];
      assign ir_v[g]       = bus.in_ready;
      assign ov_v[g]       = bus.out_valid;
      assign co_v[g]       = bus.c_out;
      assign of_v[g]       = bus.ovf;
      assign sum_v[g]      = 16'(bus.sum);
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer reference: unsigned sum for sum/c_out, signed range test for ovf.
  task automatic ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, output logic [15:0] s, output logic co,
                         output logic ov);
    longint unsigned m, t;
    longint sa, sb, ss, lim;
    m   = (64'd1 << w) - 64'd1;
    t   = (64'(a) & m) + (64'(b) & m) + 64'(cin);
    s   = 16'(t & m);
    co  = ((t >> w) & 64'd1) != 64'd0;
    lim = longint'(1) << (w - 1);
    sa  = longint'(64'(a) & m);
    sb  = longint'(64'(b) & m);
    if (sa >= lim) sa -= 2 * lim;
    if (sb >= lim) sb -= 2 * lim;
    ss  = sa + sb + longint'(cin);
    ov  = (ss >= lim) || (ss < -lim);
  endtask

  // Issues one op on config c and returns with the DUT in DONE.
  task automatic run_op(input int c, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic ordy);
    int n, lat;
    logic [15:0] es;
    logic eco, eov;
    n = CW[c] / CD[c];
    chk($sformatf("cfg%0d_idle_in_ready", c), 32'(ir_v[c]), 32'd1);
    a_v[c]    = a;
    b_v[c]    = b;
    cin_v[c]  = cin;
    ordy_v[c] = ordy;
    inv_v[c]  = 1'b1;
    step();
    inv_v[c]  = 1'b0;
    a_v[c]    = ~a;
    b_v[c]    = ~b;
    cin_v[c]  = ~cin;
    chk($sformatf("cfg%0d_busy_in_ready", c), 32'(ir_v[c]), 32'd0);
    lat = 0;
    while (ov_v[c] !== 1'b1 && lat < 4 * n + 8) begin
      step();
      lat++;
    end
    chk($sformatf("cfg%0d_latency", c), 32'(lat), 32'(n));
    ref_add(CW[c], a, b, cin, es, eco, eov);
    chk($sformatf("cfg%0d_sum", c), 32'(sum_v[c]), 32'(es));
    chk($sformatf("cfg%0d_c_out", c), 32'(co_v[c]), 32'(eco));
    chk($sformatf("cfg%0d_ovf", c), 32'(of_v[c]), 32'(eov));
  endtask

  task automatic finish_op(input int c);
    ordy_v[c] = 1'b1;
    step();
    ordy_v[c] = 1'b0;
    chk($sformatf("cfg%0d_post_hs_in_ready", c), 32'(ir_v[c]), 32'd1);
    chk($sformatf("cfg%0d_post_hs_out_valid", c), 32'(ov_v[c]), 32'd0);
  endtask

  initial begin
    logic [15:0] es;
    logic eco, eov;
    reset  = 1'b1;
    inv_v  = '0;
    cin_v  = '0;
    ordy_v = '0;
    a_v    = '0;
    b_v    = '0;
    step();
    step();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("cfg%0d_rst_in_ready", c), 32'(ir_v[c]), 32'd1);
      chk($sformatf("cfg%0d_rst_out_valid", c), 32'(ov_v[c]), 32'd0);
      chk($sformatf("cfg%0d_rst_sum", c), 32'(sum_v[c]), 32'd0);
    end
    reset = 1'b0;
    step();

    // Unsigned wrap with carry out
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b1);
    chk("t1_sum", 32'(sum_v[0]), 32'h00);
    chk("t1_c_out", 32'(co_v[0]), 32'd1);
    chk("t1_ovf", 32'(of_v[0]), 32'd0);
    finish_op(0);

    // Signed overflow cases
    run_op(0, 16'h007F, 16'h0001, 1'b0, 1'b1);
    chk("t2a_sum", 32'(sum_v[0]), 32'h80);
    chk("t2a_c_out", 32'(co_v[0]), 32'd0);
    chk("t2a_ovf", 32'(of_v[0]), 32'd1);
    finish_op(0);
    run_op(0, 16'h0080, 16'h0080, 1'b1, 1'b1);
    chk("t2b_sum", 32'(sum_v[0]), 32'h01);
    chk("t2b_c_out", 32'(co_v[0]), 32'd1);
    chk("t2b_ovf", 32'(of_v[0]), 32'd1);
    finish_op(0);

    // Back-pressure: result held for 5 cycles with out_ready low
    run_op(0, 16'h005A, 16'h00C3, 1'b1, 1'b0);
    ref_add(8, 16'h005A, 16'h00C3, 1'b1, es, eco, eov);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_out_valid", 32'(ov_v[0]), 32'd1);
      chk("bp_in_ready", 32'(ir_v[0]), 32'd0);
      chk("bp_sum", 32'(sum_v[0]), 32'(es));
      chk("bp_c_out", 32'(co_v[0]), 32'(eco));
      chk("bp_ovf", 32'(of_v[0]), 32'(eov));
    end
    finish_op(0);

    // Reset two cycles into BUSY with a live carry, then a clean op
    a_v[0] = 16'h00FF; b_v[0] = 16'h00FF; cin_v[0] = 1'b1; inv_v[0] = 1'b1;
    step();
    inv_v[0] = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(ir_v[0]), 32'd1);
    chk("mid_rst_out_valid", 32'(ov_v[0]), 32'd0);
    chk("mid_rst_sum", 32'(sum_v[0]), 32'd0);
    chk("mid_rst_c_out", 32'(co_v[0]), 32'd0);
    step();
    reset = 1'b0;
    step();
    run_op(0, 16'h0012, 16'h0034, 1'b0, 1'b1);
    chk("after_rst_sum", 32'(sum_v[0]), 32'h46);
    chk("after_rst_c_out", 32'(co_v[0]), 32'd0);
    finish_op(0);

    // in_valid held high through BUSY and DONE must be ignored
    a_v[0] = 16'h0021; b_v[0] = 16'h0042; cin_v[0] = 1'b0; inv_v[0] = 1'b1;
    ordy_v[0] = 1'b0;
    step();
    a_v[0] = 16'h00FF; b_v[0] = 16'h00FF; cin_v[0] = 1'b1;
    for (int k = 0; k < 4 + 2; k++) step();
    chk("ign_out_valid", 32'(ov_v[0]), 32'd1);
    chk("ign_sum", 32'(sum_v[0]), 32'h63);
    chk("ign_c_out", 32'(co_v[0]), 32'd0);
    inv_v[0] = 1'b0;
    finish_op(0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ign_single_hs", 32'(ov_v[0]), 32'd0);
      chk("ign_idle_in_ready", 32'(ir_v[0]), 32'd1);
    end

    // Random operands on every configuration
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < 1000; k++) begin
        logic [15:0] ra, rb;
        logic rc;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        if (k % 50 == 0) begin
          ra = 16'hFFFF;
          rb = 16'($urandom_range(0, 1));
        end
        run_op(c, ra, rb, rc, 1'b1);
        finish_op(c);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
